// File: rtl/uart_program_loader.sv
//==============================================================================
// Module      : uart_program_loader
// Description : UART boot loader for the Hack computer. An 8N1 receiver and a
//               frame parser write 16-bit words into the instruction ROM and
//               keep the CPU in reset until a complete image has been accepted.
//               Frame: A5 | LEN_HI | LEN_LO | {W_HI,W_LO} x LEN | [CHK]
//               Optional feature macro: UART_LOADER_CHECKSUM_EN (adds the CHK
//               byte, an XOR over the length and all data bytes).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_program_loader #(
    parameter int CLK_HZ       = 27_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_W       = 15,
    parameter int MAX_WORDS    = 32768,
    parameter int TIMEOUT_CLKS = 2_700_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx,
    output logic              o_rom_we,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [15:0]       o_rom_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int              CLKS_PER_BIT   = CLK_HZ / BAUD;
    localparam int              BCW            = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BCW-1:0]  C_BIT_END      = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]  C_HALF_END     = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam int              TCW            = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TCW-1:0]  C_TIMEOUT_LAST = TCW'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]     C_MAX_WORDS    = 17'(MAX_WORDS);
    localparam logic [7:0]      C_SYNC_BYTE    = 8'hA5;

    // receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // parser states
    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = 3'd5;
`endif
    localparam logic [2:0] S_FIN     = 3'd6;
    localparam logic [2:0] S_RUN     = 3'd7;

    logic           r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]     r_rx_state;
    logic [BCW-1:0] r_bcnt;
    logic [2:0]     r_bitn;
    logic [7:0]     r_byte;
    logic           r_byte_valid;
    logic           r_frame_err;

    logic [2:0]     r_state;
    logic [7:0]     r_len_hi;
    logic [15:0]    r_len;
    logic [15:0]    r_cnt;
    logic [7:0]     r_hi;
    logic [TCW-1:0] r_tcnt;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]     r_chk;
`endif

    logic [15:0]    w_len;
    logic           w_len_bad;
    logic           w_in_frame;
    logic           w_timeout;
    logic           w_last_word;

    assign w_len       = {r_len_hi, r_byte};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > C_MAX_WORDS);
    // FIN is a one-clock hop into RUN, so it never counts toward the timeout
    assign w_in_frame  = (r_state != S_SYNC) && (r_state != S_RUN) && (r_state != S_FIN);
    assign w_timeout   = w_in_frame && !r_byte_valid && (r_tcnt == C_TIMEOUT_LAST);
    assign w_last_word = (r_cnt == r_len - 16'd1);

    // 2-FF synchronizer plus 8N1 receiver; a byte is valid the clock after its stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_bcnt       <= '0;
            r_bitn       <= 3'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_bcnt <= '0;
                    // edge rather than level, so a low stop bit cannot retrigger
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_bcnt == C_HALF_END) begin
                        r_bcnt     <= '0;
                        r_bitn     <= 3'd0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_bcnt <= r_bcnt + BCW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_bcnt == C_BIT_END) begin
                        r_bcnt <= '0;
                        r_byte <= {r_rx_sync, r_byte[7:1]};
                        if (r_bitn == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_bitn <= r_bitn + 3'd1;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + BCW'(1);
                    end
                end
                default: begin
                    if (r_bcnt == C_BIT_END) begin
                        r_bcnt       <= '0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                    end else begin
                        r_bcnt <= r_bcnt + BCW'(1);
                    end
                end
            endcase
        end
    end

    // frame parser, ROM write port, CPU hold and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SYNC;
            r_len_hi    <= 8'd0;
            r_len       <= 16'd0;
            r_cnt       <= 16'd0;
            r_hi        <= 8'd0;
            r_tcnt      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_chk       <= 8'd0;
`endif
            o_rom_we    <= 1'b0;
            o_rom_addr  <= '0;
            o_rom_wdata <= 16'd0;
            o_cpu_reset <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // address advances in the clock after each write pulse
            if (o_rom_we) begin
                o_rom_we   <= 1'b0;
                o_rom_addr <= o_rom_addr + ADDR_W'(1);
            end
            if (!w_in_frame || r_byte_valid) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TCW'(1);
            end

            if (r_frame_err || w_timeout) begin
                o_err   <= 1'b1;
                o_busy  <= 1'b0;
                r_state <= S_SYNC;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (r_byte_valid && r_byte == C_SYNC_BYTE) begin
                            o_err       <= 1'b0;
                            o_busy      <= 1'b1;
                            o_cpu_reset <= 1'b1;
                            r_state     <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (r_byte_valid) begin
                            r_len_hi <= r_byte;
                            r_state  <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (r_byte_valid) begin
                            if (w_len_bad) begin
                                o_err   <= 1'b1;
                                o_busy  <= 1'b0;
                                r_state <= S_SYNC;
                            end else begin
                                r_len      <= w_len;
                                r_cnt      <= 16'd0;
                                o_rom_addr <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                                r_chk      <= r_len_hi ^ r_byte;
`endif
                                r_state    <= S_DATA_HI;
                            end
                        end
                    end
                    S_DATA_HI: begin
                        if (r_byte_valid) begin
                            r_hi    <= r_byte;
                            r_state <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: begin
                        if (r_byte_valid) begin
                            o_rom_wdata <= {r_hi, r_byte};
                            o_rom_we    <= 1'b1;
                            r_cnt       <= r_cnt + 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                            r_chk       <= r_chk ^ r_hi ^ r_byte;
                            r_state     <= w_last_word ? S_CHK : S_DATA_HI;
`else
                            r_state     <= w_last_word ? S_FIN : S_DATA_HI;
`endif
                        end
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (r_byte_valid) begin
                            if (r_byte == r_chk) begin
                                r_state <= S_FIN;
                            end else begin
                                o_err   <= 1'b1;
                                o_busy  <= 1'b0;
                                r_state <= S_SYNC;
                            end
                        end
                    end
`endif
                    S_FIN: begin
                        o_done      <= 1'b1;
                        o_cpu_reset <= 1'b0;
                        o_busy      <= 1'b0;
                        r_state     <= S_RUN;
                    end
                    S_RUN: begin
                        // a new sync byte re-arms loading and re-holds the CPU
                        if (r_byte_valid && r_byte == C_SYNC_BYTE) begin
                            o_cpu_reset <= 1'b1;
                            o_err       <= 1'b0;
                            o_busy      <= 1'b1;
                            r_state     <= S_LEN_HI;
                        end
                    end
                    default: begin
                        r_state <= S_SYNC;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
//==============================================================================
// Module      : tb_uart_program_loader
// Description : Scoreboard bench for uart_program_loader. Frames are built at
//               the byte level, expected ROM writes and done pulses are queued
//               from the frame rules, and a monitor pops them as the DUT
//               produces outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_program_loader;

    localparam int CPB     = 16;
    localparam int BAUD    = 100_000;
    localparam int CLK_HZ  = CPB * BAUD;
    localparam int ADDR_W  = 15;
    localparam int MAXW    = 8;
    localparam int TMO     = 1000;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CHK_EN  = 1'b1;
`else
    localparam bit CHK_EN  = 1'b0;
`endif

    typedef struct packed {
        logic        is_done;
        logic [14:0] addr;
        logic [15:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset, busy, done, err;

    ev_t         q[$];
    logic [15:0] g_words[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W),
        .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_rx(rx),
        .o_rom_we(rom_we), .o_rom_addr(rom_addr), .o_rom_wdata(rom_wdata),
        .o_cpu_reset(cpu_reset), .o_busy(busy), .o_done(done), .o_err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    // expected behaviour of one frame, derived from the frame rules
    task automatic run_frame(input int len, input bit corrupt, input bit with_sync);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] l16;
        logic [15:0] w;
        bit          ok, pass;
        l16  = 16'(len);
        ok   = (len >= 1) && (len <= MAXW);
        pass = ok && !(CHK_EN && corrupt);
        bytes = {};
        if (with_sync) bytes.push_back(8'hA5);
        bytes.push_back(l16[15:8]);
        bytes.push_back(l16[7:0]);
        x = l16[15:8] ^ l16[7:0];
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                w = g_words[i];
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                x = x ^ w[15:8] ^ w[7:0];
                q.push_back({1'b0, 15'(i), w});
            end
            if (CHK_EN) bytes.push_back(corrupt ? ~x : x);
            if (pass) q.push_back({1'b1, 15'd0, 16'd0});
        end
        foreach (bytes[k]) send_byte(bytes[k], 1'b1);
        tick(4);
        check("frame_err", {31'd0, err}, {31'd0, !pass});
        check("frame_cpu_reset", {31'd0, cpu_reset}, {31'd0, !pass});
        check("frame_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic random_words(input int n);
        g_words = {};
        for (int i = 0; i < n; i++) g_words.push_back(16'($urandom_range(0, 65535)));
    endtask

    // scoreboard monitor: every write or done pulse must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rom_we === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_write", {17'd0, rom_addr}, 32'hFFFFFFFF);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("write_kind", {31'd0, e.is_done}, 32'd0);
                    check("write_addr", {17'd0, rom_addr}, {17'd0, e.addr});
                    check("write_data", {16'd0, rom_wdata}, {16'd0, e.data});
                end
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("done_kind", {31'd0, e.is_done}, 32'd1);
                end
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [7:0] junk;
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_rom_we", {31'd0, rom_we}, 32'd0);
        check("rst_rom_addr", {17'd0, rom_addr}, 32'd0);
        check("rst_rom_wdata", {16'd0, rom_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // directed frames: good, bad checksum, zero length, then recovery
        g_words = '{16'h1234, 16'hABCD};
        run_frame(2, 1'b0, 1'b1);
        run_frame(2, 1'b1, 1'b1);
        run_frame(0, 1'b0, 1'b1);
        send_byte(8'h55, 1'b1);
        g_words = '{16'h7FFF};
        run_frame(1, 1'b0, 1'b1);
        run_frame(MAXW + 1, 1'b0, 1'b1);
        random_words(MAXW);
        run_frame(MAXW, 1'b0, 1'b1);

        // truncated frame: one word then silence until the timeout
        q.push_back({1'b0, 15'd0, 16'h0001});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(20);
        check("tmo_busy_before", {31'd0, busy}, 32'd1);
        check("tmo_err_before", {31'd0, err}, 32'd0);
        tick(TMO + 50);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        random_words(3);
        run_frame(3, 1'b0, 1'b1);

        // framing error, then a short glitch, then re-arm with a sync byte
        send_byte(8'h3C, 1'b0);
        tick(2);
        check("frm_err", {31'd0, err}, 32'd1);
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_err", {31'd0, err}, 32'd1);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 1'b1);
        check("rearm_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        check("rearm_err", {31'd0, err}, 32'd0);
        random_words(2);
        run_frame(2, 1'b0, 1'b0);

        // randomized frames with occasional junk bytes between them
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 1'b1);
            end
            len = $urandom_range(1, MAXW);
            random_words(len);
            run_frame(len, ($urandom_range(0, 3) == 0), 1'b1);
        end

        // reset in the middle of a frame
        q.push_back({1'b0, 15'd0, 16'h1234});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_rst_rom_addr", {17'd0, rom_addr}, 32'd0);
        check("mid_rst_rom_wdata", {16'd0, rom_wdata}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(50);
        check("post_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
